multicycle_control_unit: RTL and testbench

Multicycle MIPS control FSM that drives the ALU's 4-bit `ALUOperation` select and all datapath enables and mux selects (PC, IR, register file, memory). It sequences each instruction through fetch/decode/execute/memory/writeback, consumes the ALU's `Zero` flag for conditional branches, and stalls on a memory-ready handshake. It sits between the instruction register's opcode/funct fields and the shared single-ALU datapath.

---
 rtl/multicycle_control_unit_pkg.sv | 61 ++++++
 rtl/multicycle_control_unit_alu_op_decoder.sv | 40 ++++
 rtl/multicycle_control_unit.sv | 155 +++++++++++++++
 tb/tb_multicycle_control_unit.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_unit_pkg.sv
// Shared constants for the multicycle MIPS control path: ALU selects,
// opcode/funct fields and FSM state encoding.
package mips_ctrl_pkg;

   localparam logic [3:0] ALU_SLL = 4'd0;
   localparam logic [3:0] ALU_SRL = 4'd1;
   localparam logic [3:0] ALU_LUI = 4'd2;
   localparam logic [3:0] ALU_ADD = 4'd3;
   localparam logic [3:0] ALU_SUB = 4'd4;
   localparam logic [3:0] ALU_AND = 4'd5;
   localparam logic [3:0] ALU_NOR = 4'd7;
   localparam logic [3:0] ALU_OR  = 4'd8;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_SLL = 6'h00;
   localparam logic [5:0] FN_SRL = 6'h02;
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_NOR = 6'h27;

   localparam logic [3:0] S_FETCH     = 4'd0;
   localparam logic [3:0] S_DECODE    = 4'd1;
   localparam logic [3:0] S_MEM_ADDR  = 4'd2;
   localparam logic [3:0] S_MEM_READ  = 4'd3;
   localparam logic [3:0] S_MEM_WB    = 4'd4;
   localparam logic [3:0] S_MEM_WRITE = 4'd5;
   localparam logic [3:0] S_R_EXEC    = 4'd6;
   localparam logic [3:0] S_R_WB      = 4'd7;
   localparam logic [3:0] S_I_EXEC    = 4'd8;
   localparam logic [3:0] S_I_WB      = 4'd9;
   localparam logic [3:0] S_BRANCH    = 4'd10;
   localparam logic [3:0] S_JUMP      = 4'd11;

   // Selects which field drives the ALU operation; everything else is ADD.
   typedef enum logic [1:0] {
      CLS_DEFAULT = 2'd0,
      CLS_RTYPE   = 2'd1,
      CLS_ITYPE   = 2'd2,
      CLS_BRANCH  = 2'd3
   } alu_class_t;

   function automatic logic funct_supported(input logic [5:0] funct);
      case (funct)
         FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOR, FN_SLL, FN_SRL: return 1'b1;
         default:                                              return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/multicycle_control_unit_alu_op_decoder.sv
// Combinational ALU operation select from instruction class, opcode and funct.
module alu_op_decoder
   import mips_ctrl_pkg::*;
(
   input  logic [1:0] alu_class,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output logic [3:0] alu_operation
);

   always_comb begin
      alu_operation = ALU_ADD;
      case (alu_class_t'(alu_class))
         CLS_RTYPE: begin
            case (funct)
               FN_ADD:  alu_operation = ALU_ADD;
               FN_SUB:  alu_operation = ALU_SUB;
               FN_AND:  alu_operation = ALU_AND;
               FN_OR:   alu_operation = ALU_OR;
               FN_NOR:  alu_operation = ALU_NOR;
               FN_SLL:  alu_operation = ALU_SLL;
               FN_SRL:  alu_operation = ALU_SRL;
               default: alu_operation = ALU_ADD;
            endcase
         end
         CLS_ITYPE: begin
            case (opcode)
               OP_ADDI: alu_operation = ALU_ADD;
               OP_ANDI: alu_operation = ALU_AND;
               OP_ORI:  alu_operation = ALU_OR;
               OP_LUI:  alu_operation = ALU_LUI;
               default: alu_operation = ALU_ADD;
            endcase
         end
         CLS_BRANCH: alu_operation = ALU_SUB;
         default:    alu_operation = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control FSM: only the state is registered, every datapath
// control is decoded combinationally from state, IR fields, Zero and MemReady.
module multicycle_control_unit
   import mips_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] Opcode,
   input  logic [5:0] Funct,
   input  logic       Zero,
   input  logic       MemReady,
   output logic [3:0] ALUOperation,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       PCWrite,
   output logic       RegWrite,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic [1:0] PCSource,
   output logic       Illegal,
   output logic [3:0] State
);

   logic [3:0] state, state_next;
   logic [1:0] alu_class;
   logic       mem_read_raw, mem_write_raw, ir_write_raw;
   logic       pc_write_raw, reg_write_raw, illegal_raw;

   always_ff @(posedge clk) begin
      if (!reset) state <= S_FETCH;
      else        state <= state_next;
   end

   always_comb begin
      state_next    = state;
      alu_class     = CLS_DEFAULT;
      ALUSrcA       = 1'b0;
      ALUSrcB       = 2'd0;
      IorD          = 1'b0;
      RegDst        = 1'b0;
      MemtoReg      = 1'b0;
      PCSource      = 2'd0;
      mem_read_raw  = 1'b0;
      mem_write_raw = 1'b0;
      ir_write_raw  = 1'b0;
      pc_write_raw  = 1'b0;
      reg_write_raw = 1'b0;
      illegal_raw   = 1'b0;
      case (state)
         S_FETCH: begin
            mem_read_raw = 1'b1;
            ALUSrcB      = 2'd1;
            ir_write_raw = MemReady;
            pc_write_raw = MemReady;
            if (MemReady) state_next = S_DECODE;
         end
         S_DECODE: begin
            ALUSrcB = 2'd3;
            case (Opcode)
               OP_RTYPE: begin
                  if (funct_supported(Funct)) begin
                     state_next = S_R_EXEC;
                  end else begin
                     state_next  = S_FETCH;
                     illegal_raw = 1'b1;
                  end
               end
               OP_LW, OP_SW:                     state_next = S_MEM_ADDR;
               OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: state_next = S_I_EXEC;
               OP_BEQ, OP_BNE:                   state_next = S_BRANCH;
               OP_J:                             state_next = S_JUMP;
               default: begin
                  state_next  = S_FETCH;
                  illegal_raw = 1'b1;
               end
            endcase
         end
         S_MEM_ADDR: begin
            ALUSrcA    = 1'b1;
            ALUSrcB    = 2'd2;
            state_next = (Opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
         end
         S_MEM_READ: begin
            IorD         = 1'b1;
            mem_read_raw = 1'b1;
            if (MemReady) state_next = S_MEM_WB;
         end
         S_MEM_WB: begin
            MemtoReg      = 1'b1;
            reg_write_raw = 1'b1;
            state_next    = S_FETCH;
         end
         S_MEM_WRITE: begin
            IorD          = 1'b1;
            mem_write_raw = 1'b1;
            if (MemReady) state_next = S_FETCH;
         end
         S_R_EXEC: begin
            ALUSrcA    = 1'b1;
            alu_class  = CLS_RTYPE;
            state_next = S_R_WB;
         end
         S_R_WB: begin
            RegDst        = 1'b1;
            reg_write_raw = 1'b1;
            state_next    = S_FETCH;
         end
         S_I_EXEC: begin
            ALUSrcA    = 1'b1;
            ALUSrcB    = 2'd2;
            alu_class  = CLS_ITYPE;
            state_next = S_I_WB;
         end
         S_I_WB: begin
            reg_write_raw = 1'b1;
            state_next    = S_FETCH;
         end
         S_BRANCH: begin
            ALUSrcA      = 1'b1;
            alu_class    = CLS_BRANCH;
            PCSource     = 2'd1;
            pc_write_raw = ((Opcode == OP_BEQ) && Zero) || ((Opcode == OP_BNE) && !Zero);
            state_next   = S_FETCH;
         end
         S_JUMP: begin
            PCSource     = 2'd2;
            pc_write_raw = 1'b1;
            state_next   = S_FETCH;
         end
         default: state_next = S_FETCH;
      endcase
   end

   alu_op_decoder u_alu_op_decoder (
      .alu_class     (alu_class),
      .opcode        (Opcode),
      .funct         (Funct),
      .alu_operation (ALUOperation)
   );

   // Reset is synchronous, so gate the enables to keep a mid-instruction
   // reset cycle from committing any write.
   assign MemRead  = mem_read_raw  & reset;
   assign MemWrite = mem_write_raw & reset;
   assign IRWrite  = ir_write_raw  & reset;
   assign PCWrite  = pc_write_raw  & reset;
   assign RegWrite = reg_write_raw & reset;
   assign Illegal  = illegal_raw   & reset;
   assign State    = state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench: each instruction is expanded into its expected
// per-cycle control vectors from the instruction-level rules, then replayed.
module tb_multicycle_control_unit;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] Opcode, Funct;
   logic       Zero, MemReady;
   logic [3:0] ALUOperation;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic       IorD, MemRead, MemWrite, IRWrite, PCWrite, RegWrite;
   logic       RegDst, MemtoReg;
   logic [1:0] PCSource;
   logic       Illegal;
   logic [3:0] State;

   always #5 clk = ~clk;

   multicycle_control_unit dut (
      .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
      .MemReady(MemReady), .ALUOperation(ALUOperation), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
      .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite), .RegDst(RegDst),
      .MemtoReg(MemtoReg), .PCSource(PCSource), .Illegal(Illegal), .State(State)
   );

   // State numbers follow the order the states are listed in the design notes.
   localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEM_ADDR = 4'd2, MEM_READ = 4'd3;
   localparam logic [3:0] MEM_WB = 4'd4, MEM_WRITE = 4'd5, R_EXEC = 4'd6, R_WB = 4'd7;
   localparam logic [3:0] I_EXEC = 4'd8, I_WB = 4'd9, BRANCH = 4'd10, JUMP = 4'd11;

   typedef struct packed {
      logic [3:0] st;
      logic [3:0] op;
      logic       a;
      logic [1:0] b;
      logic       iord, mr, mw, irw, pcw, rw, rd, m2r;
      logic [1:0] pcs;
      logic       ill;
   } exp_t;

   typedef struct {
      exp_t e;
      logic mrdy;
   } cyc_t;

   cyc_t q[$];
   int   total = 0;
   int   bad   = 0;
   exp_t obs;

   assign obs = {State, ALUOperation, ALUSrcA, ALUSrcB, IorD, MemRead, MemWrite,
                 IRWrite, PCWrite, RegWrite, RegDst, MemtoReg, PCSource, Illegal};

   function automatic exp_t blank(input logic [3:0] st);
      exp_t e;
      e    = '0;
      e.st = st;
      e.op = 4'd3;
      return e;
   endfunction

   function automatic exp_t masked(input exp_t e);
      exp_t m;
      m     = e;
      m.mr  = 1'b0;
      m.mw  = 1'b0;
      m.irw = 1'b0;
      m.pcw = 1'b0;
      m.rw  = 1'b0;
      m.ill = 1'b0;
      return m;
   endfunction

   function automatic exp_t fetch_vec(input logic ready);
      exp_t e;
      e     = blank(FETCH);
      e.mr  = 1'b1;
      e.b   = 2'd1;
      e.irw = ready;
      e.pcw = ready;
      return e;
   endfunction

   function automatic logic [3:0] r_alu(input logic [5:0] f);
      case (f)
         6'h20: return 4'd3;
         6'h22: return 4'd4;
         6'h24: return 4'd5;
         6'h25: return 4'd8;
         6'h27: return 4'd7;
         6'h00: return 4'd0;
         6'h02: return 4'd1;
         default: return 4'hF;
      endcase
   endfunction

   task automatic push(input exp_t e, input logic mrdy);
      cyc_t c;
      c.e    = e;
      c.mrdy = mrdy;
      q.push_back(c);
   endtask

   task automatic build(input logic [5:0] opc, input logic [5:0] fn, input logic z,
                        input int fw, input int mwait);
      exp_t e;
      q.delete();
      for (int i = 0; i < fw; i++) push(fetch_vec(1'b0), 1'b0);
      push(fetch_vec(1'b1), 1'b1);
      e   = blank(DECODE);
      e.b = 2'd3;
      if ((opc == 6'h00 && r_alu(fn) != 4'hF) || opc == 6'h23 || opc == 6'h2B ||
          opc == 6'h08 || opc == 6'h0C || opc == 6'h0D || opc == 6'h0F ||
          opc == 6'h04 || opc == 6'h05 || opc == 6'h02) begin
         push(e, 1'($urandom));
      end else begin
         e.ill = 1'b1;
         push(e, 1'($urandom));
         return;
      end
      case (opc)
         6'h00: begin
            e = blank(R_EXEC); e.a = 1'b1; e.op = r_alu(fn); push(e, 1'($urandom));
            e = blank(R_WB); e.rd = 1'b1; e.rw = 1'b1; push(e, 1'($urandom));
         end
         6'h23, 6'h2B: begin
            e = blank(MEM_ADDR); e.a = 1'b1; e.b = 2'd2; push(e, 1'($urandom));
            e = blank(opc == 6'h23 ? MEM_READ : MEM_WRITE);
            e.iord = 1'b1;
            if (opc == 6'h23) e.mr = 1'b1; else e.mw = 1'b1;
            for (int i = 0; i < mwait; i++) push(e, 1'b0);
            push(e, 1'b1);
            if (opc == 6'h23) begin
               e = blank(MEM_WB); e.m2r = 1'b1; e.rw = 1'b1; push(e, 1'($urandom));
            end
         end
         6'h04, 6'h05: begin
            e = blank(BRANCH); e.a = 1'b1; e.op = 4'd4; e.pcs = 2'd1;
            e.pcw = (opc == 6'h04) ? z : !z;
            push(e, 1'($urandom));
         end
         6'h02: begin
            e = blank(JUMP); e.pcs = 2'd2; e.pcw = 1'b1; push(e, 1'($urandom));
         end
         default: begin
            e = blank(I_EXEC); e.a = 1'b1; e.b = 2'd2;
            e.op = (opc == 6'h0C) ? 4'd5 : (opc == 6'h0D) ? 4'd8 : (opc == 6'h0F) ? 4'd2 : 4'd3;
            push(e, 1'($urandom));
            e = blank(I_WB); e.rw = 1'b1; push(e, 1'($urandom));
         end
      endcase
   endtask

   // rst_back > 0 pulls reset low on that cycle counted from the end and abandons.
   task automatic run(input logic [5:0] opc, input logic [5:0] fn, input logic z,
                      input int fw, input int mwait, input string tag, input int rst_back);
      exp_t exp;
      int   stop_at;
      build(opc, fn, z, fw, mwait);
      stop_at = (rst_back > 0) ? q.size() - rst_back : -1;
      for (int k = 0; k < q.size(); k++) begin
         @(negedge clk);
         Opcode   = opc;
         Funct    = fn;
         Zero     = z;
         MemReady = q[k].mrdy;
         reset    = (k == stop_at) ? 1'b0 : 1'b1;
         exp      = (k == stop_at) ? masked(q[k].e) : q[k].e;
         #1;
         total++;
         assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc%0d observed=%h expected=%h", tag, k, obs, exp);
         end
         if (k == stop_at) break;
      end
   endtask

   initial begin
      logic [5:0] opcs [12];
      logic [5:0] fns  [9];
      logic [5:0] o, f;
      opcs = '{6'h00, 6'h23, 6'h2B, 6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h04, 6'h05, 6'h02, 6'h3F, 6'h03};
      fns  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h00, 6'h02, 6'h18, 6'h21};

      reset = 1'b0; Opcode = '0; Funct = '0; Zero = 1'b0; MemReady = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #1;
      total++;
      assert (obs === masked(fetch_vec(1'b1))) else begin
         bad++;
         $error("FAIL reset observed=%h expected=%h", obs, masked(fetch_vec(1'b1)));
      end

      run(6'h00, 6'h20, 1'b0, 0, 0, "add", 0);
      run(6'h23, 6'h00, 1'b0, 0, 2, "lw_wait", 0);
      run(6'h04, 6'h00, 1'b1, 0, 0, "beq_taken", 0);
      run(6'h04, 6'h00, 1'b0, 0, 0, "beq_not", 0);
      run(6'h05, 6'h00, 1'b1, 0, 0, "bne_not", 0);
      run(6'h05, 6'h00, 1'b0, 0, 0, "bne_taken", 0);
      run(6'h0F, 6'h00, 1'b0, 1, 0, "lui", 0);
      run(6'h3F, 6'h00, 1'b0, 0, 0, "ill_op", 0);
      run(6'h00, 6'h18, 1'b0, 0, 0, "ill_funct", 0);
      run(6'h2B, 6'h00, 1'b0, 1, 2, "sw_reset", 3);
      run(6'h2B, 6'h00, 1'b0, 0, 1, "sw", 0);
      run(6'h02, 6'h00, 1'b0, 2, 0, "j", 0);

      for (int n = 0; n < 150; n++) begin
         o = opcs[$urandom_range(0, 11)];
         f = fns[$urandom_range(0, 8)];
         run(o, f, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2), "random", 0);
      end

      @(negedge clk);
      MemReady = 1'b0;
      #1;
      total++;
      assert (obs === fetch_vec(1'b0)) else begin
         bad++;
         $error("FAIL final_fetch observed=%h expected=%h", obs, fetch_vec(1'b0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
